// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, access-length encodings and address helpers for mem_ctrl.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR,
        IO_STALL
    } state_e;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // Encoding 2'b11 is not a legal length; it is treated as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_addr(input logic [31:0] addr, input int io_bit);
        return addr[io_bit -: 2] == 2'b11;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-bus initiator: serializes fetch / load-store words into byte cycles; reads end n+2 cycles after sampling, writes n+1.
// rdy_in low freezes everything and re-issues in-flight reads; io_buffer_full holds I/O writes in IO_STALL.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_BIT     = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_len,
    input  logic [31:0]           ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  last_q, last_d;
    logic        io_q, io_d;
    logic        forced_q, forced_d;
    logic [1:0]  iss_q, iss_d;
    logic        iss_done_q, iss_done_d;
    logic [1:0]  cap_q, cap_d;
    logic        pend_q, pend_d;
    logic        paused_q;
    logic [31:0] asm_q, asm_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic [1:0]  iss_e;
    logic        iss_done_e;
    logic        pend_e;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_dout;

    // First cycle after a pause: restart issuing at the oldest uncaptured byte
    // and drop whatever mem_din carries, since it belongs to the paused window.
    assign iss_e      = paused_q ? cap_q : iss_q;
    assign iss_done_e = paused_q ? 1'b0  : iss_done_q;
    assign pend_e     = pend_q & ~paused_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        io_d       = io_q;
        forced_d   = forced_q;
        iss_d      = iss_q;
        iss_done_d = iss_done_q;
        cap_d      = cap_q;
        pend_d     = 1'b0;
        asm_d      = asm_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;
        bus_a      = '0;
        bus_wr     = 1'b0;
        bus_dout   = '0;

        case (state_q)
            IDLE: begin
                if (!if_done_q && !ls_done_q) begin
                    if (ls_req) begin
                        base_d     = ls_addr;
                        wdata_d    = ls_wdata;
                        last_d     = 2'(len_bytes(ls_len) - 3'd1);
                        io_d       = is_io_addr(ls_addr, IO_BIT);
                        forced_d   = 1'b0;
                        iss_d      = '0;
                        iss_done_d = 1'b0;
                        cap_d      = '0;
                        asm_d      = '0;
                        if (!ls_wr) begin
                            state_d = LS_RD;
                        end else if (is_io_addr(ls_addr, IO_BIT) && io_buffer_full) begin
                            state_d = IO_STALL;
                        end else begin
                            state_d = LS_WR;
                        end
                    end else if (if_req && !clr_in) begin
                        base_d     = if_addr;
                        last_d     = 2'd3;
                        io_d       = 1'b0;
                        forced_d   = 1'b0;
                        iss_d      = '0;
                        iss_done_d = 1'b0;
                        cap_d      = '0;
                        asm_d      = '0;
                        state_d    = IF_RD;
                    end
                end
            end

            IF_RD, LS_RD: begin
                if (!iss_done_e) begin
                    bus_a      = base_q + {30'd0, iss_e};
                    iss_d      = iss_e + 2'd1;
                    iss_done_d = (iss_e == last_q);
                    pend_d     = 1'b1;
                end
                if (pend_e) begin
                    asm_d[{cap_q, 3'b000} +: 8] = mem_din;
                    cap_d = cap_q + 2'd1;
                    if (cap_q == last_q) begin
                        state_d = IDLE;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = asm_d;
                        end
                    end
                end
                if (state_q == IF_RD && clr_in) begin
                    state_d   = IDLE;
                    pend_d    = 1'b0;
                    if_done_d = 1'b0;
                    if_data_d = if_data_q;
                end
            end

            LS_WR: begin
                bus_a    = base_q + {30'd0, iss_q};
                bus_wr   = 1'b1;
                bus_dout = wdata_q[{iss_q, 3'b000} +: 8];
                iss_d    = iss_q + 2'd1;
                if (io_q) begin
                    // io_buffer_full reflects this byte only one cycle late.
                    state_d    = IO_STALL;
                    forced_d   = 1'b1;
                    iss_done_d = (iss_q == last_q);
                end else if (iss_q == last_q) begin
                    state_d   = IDLE;
                    ls_done_d = 1'b1;
                end
            end

            IO_STALL: begin
                if (forced_q) begin
                    forced_d = 1'b0;
                    if (iss_done_q) begin
                        state_d   = IDLE;
                        ls_done_d = 1'b1;
                    end
                end else if (!io_buffer_full) begin
                    state_d = LS_WR;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            base_q     <= '0;
            wdata_q    <= '0;
            last_q     <= '0;
            io_q       <= 1'b0;
            forced_q   <= 1'b0;
            iss_q      <= '0;
            iss_done_q <= 1'b0;
            cap_q      <= '0;
            pend_q     <= 1'b0;
            paused_q   <= 1'b0;
            asm_q      <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            paused_q <= ~rdy_in;
            if (rdy_in) begin
                state_q    <= state_d;
                base_q     <= base_d;
                wdata_q    <= wdata_d;
                last_q     <= last_d;
                io_q       <= io_d;
                forced_q   <= forced_d;
                iss_q      <= iss_d;
                iss_done_q <= iss_done_d;
                cap_q      <= cap_d;
                pend_q     <= pend_d;
                asm_q      <= asm_d;
                if_done_q  <= if_done_d;
                if_data_q  <= if_data_d;
                ls_done_q  <= ls_done_d;
                ls_rdata_q <= ls_rdata_d;
            end
        end
    end

    assign mem_a    = rdy_in ? ADDR_WIDTH'(bus_a) : '0;
    assign mem_wr   = rdy_in & bus_wr;
    assign mem_dout = rdy_in ? bus_dout : 8'd0;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered-read byte RAM and an I/O write logger.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int checks = 0;
    int errors = 0;
    int io_wr_cnt = 0;
    logic [7:0] io_last = 8'd0;
    logic [7:0] ram [0:1023];

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clr_in         (clr_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_len         (ls_len),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    // RAM preload on reset; ram[0] is distinctive so a stray capture of the idle bus shows up.
    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[0]      <= 8'hEE;
            ram[10'h20] <= 8'h5A;
            ram[10'h100] <= 8'h13;
            ram[10'h101] <= 8'h05;
            ram[10'h102] <= 8'h00;
            ram[10'h103] <= 8'h00;
        end else if (mem_wr && mem_a[17:16] == 2'b11) begin
            io_wr_cnt <= io_wr_cnt + 1;
            io_last   <= mem_dout;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one load/store from an idle cycle; lat = cycles until ls_done, then one idle cycle.
    task automatic ls_xfer(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat);
        ls_req = 1'b1; ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wd;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            lat++;
            if (ls_done) break;
        end
        ls_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int io0;
        int pulses;

        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = '0; ls_wdata = '0;
        repeat (3) tick();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 32'h0);
        chk("rst_if_done", if_done, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;
        tick();

        // 4-byte fetch from 0x100
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fetch_addr", mem_a, 32'h100 + k);
        end
        tick();
        chk("fetch_not_yet", if_done, 32'h0);
        tick();
        chk("fetch_done", if_done, 32'h1);
        chk("fetch_data", if_data, 32'h00000513);
        if_req = 1'b0;
        tick();
        chk("fetch_pulse_1cyc", if_done, 32'h0);

        // simultaneous requests: load/store wins, fetch follows one idle cycle later
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("arb_ls_first", mem_a, 32'h20);
        tick();
        chk("arb_ls_not_yet", ls_done, 32'h0);
        tick();
        chk("arb_ls_done", ls_done, 32'h1);
        chk("arb_ls_data", ls_rdata, 32'h5A);
        chk("arb_if_waits", if_done, 32'h0);
        ls_req = 1'b0;
        tick();
        chk("arb_idle_gap", mem_a, 32'h0);
        tick();
        chk("arb_fetch_start", mem_a, 32'h100);
        repeat (5) tick();
        chk("arb_fetch_done", if_done, 32'h1);
        chk("arb_fetch_data", if_data, 32'h00000513);
        if_req = 1'b0;
        tick();

        // halfword store then read back
        ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b01; ls_addr = 32'h40; ls_wdata = 32'hAABBCCDD;
        tick();
        chk("st_a0", mem_a, 32'h40);
        chk("st_wr0", mem_wr, 32'h1);
        chk("st_d0", mem_dout, 32'hDD);
        tick();
        chk("st_a1", mem_a, 32'h41);
        chk("st_d1", mem_dout, 32'hCC);
        tick();
        chk("st_done", ls_done, 32'h1);
        chk("st_bus_released", mem_wr, 32'h0);
        ls_req = 1'b0;
        tick();
        ls_xfer(1'b0, 2'b01, 32'h40, 32'h0, lat);
        chk("ld_h_latency", lat, 32'd4);
        chk("ld_h_data", ls_rdata, 32'h0000CCDD);

        // I/O write, FIFO not full: byte, forced stall, done
        ls_xfer(1'b1, 2'b00, 32'h30000, 32'h55, lat);
        chk("io_latency", lat, 32'd3);

        // I/O write with FIFO full for 5 cycles
        io0 = io_wr_cnt;
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h41;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("bp_idle_wr", mem_wr, 32'h0);
            chk("bp_idle_a", mem_a, 32'h0);
            if (i == 5) io_buffer_full = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_wr) break;
        end
        chk("bp_write", mem_wr, 32'h1);
        chk("bp_addr", mem_a, 32'h30000);
        chk("bp_byte", mem_dout, 32'h41);
        tick();
        chk("bp_stall_no_wr", mem_wr, 32'h0);
        chk("bp_stall_no_done", ls_done, 32'h0);
        tick();
        chk("bp_done", ls_done, 32'h1);
        ls_req = 1'b0;
        tick();
        chk("bp_single_write", io_wr_cnt - io0, 32'd1);
        chk("bp_io_byte", io_last, 32'h41);

        // pause for 3 cycles from T+3 of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        chk("ps_pre_addr", mem_a, 32'h101);
        tick();
        rdy_in = 1'b0;
        #1;
        chk("ps_bus_idle", mem_a, 32'h0);
        tick();
        tick();
        chk("ps_no_done", if_done, 32'h0);
        tick();
        rdy_in = 1'b1;
        #1;
        chk("ps_reissue", mem_a, 32'h101);
        tick();
        chk("ps_addr2", mem_a, 32'h102);
        tick();
        chk("ps_addr3", mem_a, 32'h103);
        tick();
        chk("ps_not_yet", if_done, 32'h0);
        tick();
        chk("ps_done", if_done, 32'h1);
        chk("ps_data", if_data, 32'h00000513);
        if_req = 1'b0;
        tick();

        // flush at T+2 of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        clr_in = 1'b1; if_req = 1'b0;
        tick();
        clr_in = 1'b0;
        chk("fl_bus_idle", mem_a, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (if_done) pulses++;
            tick();
        end
        chk("fl_no_if_done", pulses, 32'd0);

        // flush and fetch request together in IDLE
        clr_in = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fl_same_cycle_idle", mem_a, 32'h0);
        clr_in = 1'b0; if_req = 1'b0;
        tick();
        chk("fl_same_cycle_stays_idle", mem_a, 32'h0);

        // reset in the middle of a word store
        ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b10; ls_addr = 32'h80; ls_wdata = 32'h11223344;
        tick();
        chk("rs_first_byte", mem_dout, 32'h44);
        tick();
        rst_in = 1'b1;
        tick();
        chk("rs_mem_a", mem_a, 32'h0);
        chk("rs_mem_wr", mem_wr, 32'h0);
        chk("rs_mem_dout", mem_dout, 32'h0);
        chk("rs_ls_done", ls_done, 32'h0);
        chk("rs_if_data", if_data, 32'h0);
        chk("rs_ls_rdata", ls_rdata, 32'h0);
        ls_req = 1'b0;
        rst_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (ls_done) pulses++;
            tick();
        end
        chk("rs_no_ls_done", pulses, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

CPU-side initiator for the byte-wide system memory bus (`mem_a`/`mem_wr`/`mem_dout` out, `mem_din` in) that the top level routes to the 128 KiB RAM and to the HCI I/O window. It accepts word-level requests from instruction fetch and from the load/store unit and serializes them into single-byte bus transactions. It handles the one-cycle registered read latency, the HCI pause (`rdy_in`), and back-pressure from `io_buffer_full`.

## Interface

Parameters:
- `ADDR_WIDTH`, 32: width of `mem_a` and the request addresses.
- `IO_BIT`, 17: I/O window is decoded when `addr[IO_BIT:IO_BIT-1] == 2'b11`.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: 0 means the HCI owns the bus. Internal state is frozen.
- `clr_in` in 1: flush. Aborts an in-flight instruction fetch only.
- `mem_din` in 8: byte returned by the bus one cycle after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out `ADDR_WIDTH`: byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: HCI output FIFO full.
- `if_req` in 1, `if_addr` in 32: 4-byte instruction read request.
- `if_done` out 1, `if_data` out 32: one-cycle completion pulse and the little-endian word.
- `ls_req` in 1, `ls_wr` in 1, `ls_len` in 2 (00 = 1 B, 01 = 2 B, 10 = 4 B), `ls_addr` in 32, `ls_wdata` in 32: data request.
- `ls_done` out 1, `ls_rdata` out 32: one-cycle completion pulse and the zero-extended read data.

## Operation

- **States:** IDLE, IF_RD, LS_RD, LS_WR, IO_STALL.
- **Request protocol:** a requester holds `req` and its arguments stable until its `done` pulse.
- **IDLE sampling:**
  - IDLE samples requests only when neither `done` output is high. This guarantees one idle cycle between transactions.
  - `ls_req` has priority over `if_req`.
- **No preemption:** a transaction, once started, runs to completion.
- **Byte order:** byte k uses address `base+k`, for k = 0..n-1. Bytes are little-endian, so byte k goes to bits [8k+7:8k].
- **Reads:**
  - Issue address k in one cycle; capture `mem_din` as byte k at the end of the next cycle.
  - Addresses are pipelined back-to-back.
  - A byte counter tracks issued bytes; a second counter tracks captured bytes.
- **Writes:** one byte per cycle with `mem_wr=1` and `mem_dout = wdata[8k+7:8k]`.
- **Idle bus:** in IDLE and IO_STALL, drive `mem_a=0`, `mem_wr=0`, `mem_dout=0`.
- **I/O write:**
  - Before presenting a write byte to the I/O window, check `io_buffer_full`. While it is 1, go to IO_STALL and hold.
  - After every I/O write byte, insert one forced IO_STALL cycle, because `io_buffer_full` lags by one cycle.
- **I/O read:** only 1-byte I/O accesses are legal. Wider lengths are undefined.
- **`rdy_in=0`:**
  - Freeze all registers and drive the bus idle.
  - Discard any capture that falls in the paused window.
  - On the first cycle with `rdy_in=1`, re-issue from the oldest uncaptured byte. The issue counter is set back to the capture counter.
- **`clr_in=1` during IF_RD:**
  - Go to IDLE next cycle with no `if_done`.
  - A data capture arriving the next cycle is ignored.
- **`clr_in` outside IF_RD:** no effect on LS transactions.
- **`clr_in` and `if_req` in the same IDLE cycle:** the fetch is not started.
- **Reset:** state IDLE, counters 0; all outputs 0, including `if_data` and `ls_rdata`.
- **Reset mid-transaction:** abandons it with no `done` pulse.

## Timing

- **Reference point:** T is the IDLE cycle in which `req` is sampled.
- **Read of n bytes:**
  - Address k appears in cycle T+1+k.
  - Byte k is captured at the end of T+2+k.
  - `done` and data are visible in T+n+2, so a 4 B fetch completes in T+6.
- **Write of n bytes, RAM target:** bytes appear in T+1..T+n; `ls_done` is visible in T+n+1.
- **I/O write of 1 byte with FIFO not full:** the byte appears in T+1, the forced stall is T+2, and `ls_done` is visible in T+3.
- **Pause:** each cycle with `rdy_in=0` adds exactly one cycle, plus one re-issue cycle per read byte that was in flight.
- **Done pulses:** `done` is high for exactly one cycle; `if_done` and `ls_done` are never both high.

## Structure

- **Shared package `mem_ctrl_pkg`:**
  - state enum;
  - `ls_len` encodings `LEN_B`/`LEN_H`/`LEN_W`;
  - the length-to-byte-count function;
  - the I/O window decode function.
- **Sub-modules:** none. Keep it as a single module.
- **Counters and assembly:** the issue and capture counters are 2-bit plus a done flag; the assembly register is 32 bits.

## Test plan

- **Fetch:** `if_addr=0x100`, RAM holds 13 05 00 00.
  - `mem_a` steps 0x100..0x103 in T+1..T+4.
  - `if_done` in T+6 with `if_data=0x00000513`.
- **Arbitration:** `ls_req` (1 B read at 0x20) and `if_req` asserted in the same cycle.
  - LS is served first; `ls_done` in T+3.
  - The fetch starts after one idle cycle.
- **Halfword store:** `ls_wdata=0xAABBCCDD` to 0x40.
  - Writes DD at 0x40 and CC at 0x41 with `mem_wr=1`.
  - `ls_done` in T+3; RAM reads back 0xCCDD.
- **I/O back-pressure:** 1 B write of 0x41 to 0x30000 with `io_buffer_full=1` for 5 cycles.
  - Bus idle for those cycles.
  - Single write after release; `ls_done` two cycles later.
- **Pause re-issue:** `rdy_in=0` for 3 cycles starting at T+3 of a fetch.
  - Bytes captured before the pause are kept.
  - Re-issue starts at the first uncaptured address.
  - The final word is correct.
- **Flush and reset:**
  - `clr_in` at T+2 of a fetch gives no `if_done` and the bus idle next cycle.
  - `rst_in` mid-store gives no `ls_done` and all outputs 0.
